// File: rtl/bs_pkg.sv
// Shared types and helpers for the bus generator/arbiter: FSM states, header width, broadcast ID.
package bs_pkg;

  typedef enum logic [1:0] {IDLE, POP, PUSH} bs_state_e;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST = 8'hFF;
  localparam int PKT_MAX_W = 256;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Destination ID sits in the top ID_W bits of a pkt_w-wide packet.
  function automatic logic [ID_W-1:0] dest_id(input logic [PKT_MAX_W-1:0] pkt, input int pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/bs_rr_arbiter.sv
// Round-robin pick among pending drivers, searching upward from rr_ptr with wrap.
// Purely combinational; a pending driver is granted within drvrs arbitration rounds.
module bs_rr_arbiter
  import bs_pkg::*;
#(
  parameter int drvrs = 4,
  localparam int IDX_W = idx_w(drvrs)
) (
  input  logic [drvrs-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  always_comb begin : arb
    int unsigned k;
    logic [IDX_W-1:0] idx;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    k       = 0;
    idx     = '0;
    for (int i = 0; i < drvrs; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= drvrs) k = k - drvrs;
      idx = IDX_W'(k);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/bs_gnrtr_n_rbtr.sv
// Per-bus FSM: arbitrate, pop one packet, push to decoded destination(s); 3 cycles per packet, no stall input.
// Optional BS_DROP_CNT_EN adds a saturating per-bus counter of packets dropped for an invalid destination.
module bs_gnrtr_n_rbtr
  import bs_pkg::*;
#(
  parameter int              bits      = 1,
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng  [bits-1:0][drvrs-1:0],
  input  logic [pckg_sz-1:0] D_pop  [bits-1:0][drvrs-1:0],
  output logic               pop    [bits-1:0][drvrs-1:0],
  output logic               push   [bits-1:0][drvrs-1:0],
  output logic [pckg_sz-1:0] D_push [bits-1:0][drvrs-1:0]
`ifdef BS_DROP_CNT_EN
  ,
  output logic [7:0]         drop_cnt [bits-1:0]
`endif
);

  localparam int IDX_W = idx_w(drvrs);

  for (genvar b = 0; b < bits; b++) begin : g_bus
    bs_state_e          state_q, state_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d, rr_q, rr_d, arb_idx;
    logic               arb_vld;
    logic [pckg_sz-1:0] data_q, data_d;
    logic [drvrs-1:0]   req, push_vec;
    logic [ID_W-1:0]    dst;

    for (genvar i = 0; i < drvrs; i++) begin : g_drv
      assign req[i]       = pndng[b][i];
      assign pop[b][i]    = (state_q == POP) && (gnt_q == IDX_W'(i));
      assign push[b][i]   = push_vec[i];
      assign D_push[b][i] = data_q;
    end

    bs_rr_arbiter #(.drvrs(drvrs)) u_arb (
      .req     (req),
      .rr_ptr  (rr_q),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
    );

    assign dst = dest_id(PKT_MAX_W'(data_q), pckg_sz);

    always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      rr_d     = rr_q;
      data_d   = data_q;
      push_vec = '0;
      case (state_q)
        IDLE: begin
          if (arb_vld) begin
            gnt_d   = arb_idx;
            state_d = POP;
          end
        end
        POP: begin
          data_d  = D_pop[b][gnt_q];
          state_d = PUSH;
        end
        PUSH: begin
          // Unicast wins over broadcast should the two ID ranges ever overlap.
          for (int i = 0; i < drvrs; i++) begin
            if (dst < ID_W'(drvrs)) push_vec[i] = (dst == ID_W'(i));
            else if (dst == broadcast) push_vec[i] = (gnt_q != IDX_W'(i));
          end
          rr_d    = (gnt_q == IDX_W'(drvrs - 1)) ? '0 : gnt_q + 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        gnt_q   <= '0;
        rr_q    <= '0;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        gnt_q   <= gnt_d;
        rr_q    <= rr_d;
        data_q  <= data_d;
      end
    end

`ifdef BS_DROP_CNT_EN
    logic       is_drop;
    logic [7:0] drop_q, drop_d;

    assign is_drop = (dst >= ID_W'(drvrs)) && (dst != broadcast);

    always_comb begin
      drop_d = drop_q;
      if ((state_q == PUSH) && is_drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) drop_q <= '0;
      else       drop_q <= drop_d;
    end

    assign drop_cnt[b] = drop_q;
`endif
  end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Directed bench for bs_gnrtr_n_rbtr: unicast, broadcast, fairness, invalid ID, mid-transaction reset, idle.
module tb_bs_gnrtr_n_rbtr;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng  [0:0][3:0];
  logic [15:0] D_pop  [0:0][3:0];
  logic        pop    [0:0][3:0];
  logic        push   [0:0][3:0];
  logic [15:0] D_push [0:0][3:0];
`ifdef BS_DROP_CNT_EN
  logic [7:0]  drop_cnt [0:0];
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [3:0] pop_v, push_v;
  assign pop_v  = {pop[0][3], pop[0][2], pop[0][1], pop[0][0]};
  assign push_v = {push[0][3], push[0][2], push[0][1], push[0][0]};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bs_gnrtr_n_rbtr #(
    .bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .D_pop  (D_pop),
    .pop    (pop),
    .push   (push),
    .D_push (D_push)
`ifdef BS_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pop(input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (pop_v != 4'b0) found = 1'b1;
    end
  endtask

  initial begin
    logic found;
    int   last_pop;
    int   activity;

    last_pop = 0;
    activity = 0;
    reset    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pndng[0][i] = 1'b0;
      D_pop[0][i] = 16'h0000;
    end
    #2;
    check_eq("rst_pop",    32'(pop_v), 32'h0);
    check_eq("rst_push",   32'(push_v), 32'h0);
    check_eq("rst_dpush0", 32'(D_push[0][0]), 32'h0);
    check_eq("rst_dpush3", 32'(D_push[0][3]), 32'h0);
`ifdef BS_DROP_CNT_EN
    check_eq("rst_drop",   32'(drop_cnt[0]), 32'h0);
`endif

    // Unicast 0 -> 1, repeating while pending
    pndng[0][0] = 1'b1;
    D_pop[0][0] = 16'h0103;
    #98;
    step();
    check_eq("rst_hold_pop", 32'(pop_v), 32'h0);
    reset = 1'b0;
    step();
    check_eq("uni_pop",       32'(pop_v), 32'b0001);
    check_eq("uni_pop_nopush", 32'(push_v), 32'h0);
    step();
    check_eq("uni_pop_off",   32'(pop_v), 32'h0);
    check_eq("uni_push",      32'(push_v), 32'b0010);
    check_eq("uni_data0",     32'(D_push[0][0]), 32'h0103);
    check_eq("uni_data3",     32'(D_push[0][3]), 32'h0103);
    step();
    check_eq("uni_gap_pop",   32'(pop_v), 32'h0);
    check_eq("uni_gap_push",  32'(push_v), 32'h0);
    step();
    check_eq("uni_repeat_pop", 32'(pop_v), 32'b0001);
    step();
    check_eq("uni_repeat_push", 32'(push_v), 32'b0010);
    pndng[0][0] = 1'b0;

    // Broadcast from driver 2
    pndng[0][2] = 1'b1;
    D_pop[0][2] = 16'hFF55;
    wait_pop(6, found);
    check_eq("bc_found", 32'(found), 32'h1);
    check_eq("bc_pop",   32'(pop_v), 32'b0100);
    pndng[0][2] = 1'b0;
    step();
    check_eq("bc_push",  32'(push_v), 32'b1011);
    check_eq("bc_data",  32'(D_push[0][2]), 32'hFF55);

    // Reset asserted during POP
    pndng[0][1] = 1'b1;
    D_pop[0][1] = 16'h0212;
    wait_pop(6, found);
    check_eq("mid_found", 32'(found), 32'h1);
    check_eq("mid_pop",   32'(pop_v), 32'b0010);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_pop",   32'(pop_v), 32'h0);
    check_eq("mid_rst_push",  32'(push_v), 32'h0);
    check_eq("mid_rst_dpush", 32'(D_push[0][0]), 32'h0);
    step();
    check_eq("mid_rst_nopush", 32'(push_v), 32'h0);

    // Fairness: all pending, all addressed to driver 0
    for (int i = 0; i < 4; i++) begin
      pndng[0][i] = 1'b1;
      D_pop[0][i] = 16'h0010 + 16'(i);
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_pop(6, found);
      check_eq($sformatf("fair_found%0d", k), 32'(found), 32'h1);
      check_eq($sformatf("fair_pop%0d", k), 32'(pop_v), 32'(1 << (k % 4)));
      if (k > 0) check_eq($sformatf("fair_gap%0d", k), 32'(cyc - last_pop), 32'd3);
      last_pop = cyc;
      step();
      check_eq($sformatf("fair_push%0d", k), 32'(push_v), 32'b0001);
      check_eq($sformatf("fair_data%0d", k), 32'(D_push[0][1]), 32'h0010 + 32'(k % 4));
    end
    for (int i = 0; i < 4; i++) pndng[0][i] = 1'b0;

    // Invalid destination 0x07; pndng dropped mid-transaction
    pndng[0][1] = 1'b1;
    D_pop[0][1] = 16'h0712;
    wait_pop(6, found);
    check_eq("inv_found", 32'(found), 32'h1);
    check_eq("inv_pop",   32'(pop_v), 32'b0010);
    pndng[0][1] = 1'b0;
    step();
    check_eq("inv_nopush", 32'(push_v), 32'h0);
    check_eq("inv_data",   32'(D_push[0][0]), 32'h0712);
    step();
`ifdef BS_DROP_CNT_EN
    check_eq("inv_drop1", 32'(drop_cnt[0]), 32'd1);
`endif

    // Boundary: ID equal to drvrs is invalid
    pndng[0][3] = 1'b1;
    D_pop[0][3] = 16'h04AA;
    wait_pop(6, found);
    check_eq("bnd_found", 32'(found), 32'h1);
    check_eq("bnd_pop",   32'(pop_v), 32'b1000);
    pndng[0][3] = 1'b0;
    step();
    check_eq("bnd_nopush", 32'(push_v), 32'h0);
    step();
`ifdef BS_DROP_CNT_EN
    check_eq("bnd_drop2", 32'(drop_cnt[0]), 32'd2);
`endif

    // Idle: nothing pending
    for (int i = 0; i < 50; i++) begin
      step();
      if (pop_v != 4'b0 || push_v != 4'b0) activity++;
    end
    check_eq("idle_activity", 32'(activity), 32'h0);
    check_eq("idle_hold",     32'(D_push[0][2]), 32'h04AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
